// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pkg: shared condition codes, NZCV bit indices and stage bundle.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Post-Execute slot: write enables are already predicated by CondEx.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic pc_src;
    } ctrl_stage_t;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cond_eval: combinational ARM condition-field check against NZCV.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pipe: Decode->Execute->Memory(xMEM_STAGES)->Writeback control path  |
// | with condition predication, freeze and optional counters (CTRL_PERF_EN). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W   = 3,
    parameter int MEM_STAGES = 1,
    parameter int PERF_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ValidD,
    input  logic                PCSrcD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic                ALUSrcD,
    input  logic                NoWriteD,
    input  logic [1:0]          FlagWriteD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [3:0]          CondD,
    input  logic [3:0]          ALUFlags,
    input  logic                FlushE,
    input  logic                MemReady,
    output logic                ALUSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                MemtoRegE,
    output logic                CondExE,
    output logic                BranchTakenE,
    output logic                MemWriteM,
    output logic                RegWriteM,
    output logic                PCSrcM,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                PCSrcW,
    output logic                PCBusy,
    output logic [3:0]          Flags,
    output logic [PERF_W-1:0]   PerfRetired,
    output logic [PERF_W-1:0]   PerfSquashed,
    output logic [PERF_W-1:0]   PerfStall
);

    logic                r_valid_e, r_pcsrc_e, r_regwrite_e, r_memtoreg_e;
    logic                r_memwrite_e, r_branch_e, r_alusrc_e, r_nowrite_e;
    logic [1:0]          r_flagwrite_e;
    logic [ALUCTL_W-1:0] r_aluctl_e;
    logic [3:0]          r_cond_e;
    logic [3:0]          r_flags;
    ctrl_stage_t         r_mem [MEM_STAGES];
    ctrl_stage_t         r_wb;
    ctrl_stage_t         w_stage_e;
    logic                w_pass;
    logic                w_unused;

    cond_eval u_cond_eval (
        .i_cond  (r_cond_e),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    assign CondExE      = r_valid_e & w_pass;
    assign BranchTakenE = r_branch_e & CondExE;

    always_comb begin
        w_stage_e            = '0;
        w_stage_e.valid      = r_valid_e;
        w_stage_e.reg_write  = r_regwrite_e & CondExE & ~r_nowrite_e;
        w_stage_e.mem_to_reg = r_memtoreg_e;
        w_stage_e.mem_write  = r_memwrite_e & CondExE;
        w_stage_e.pc_src     = r_pcsrc_e & CondExE;
    end

    // A freeze also swallows FlushE; the hazard unit keeps the Decode slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_e     <= 1'b0;
            r_pcsrc_e     <= 1'b0;
            r_regwrite_e  <= 1'b0;
            r_memtoreg_e  <= 1'b0;
            r_memwrite_e  <= 1'b0;
            r_branch_e    <= 1'b0;
            r_alusrc_e    <= 1'b0;
            r_nowrite_e   <= 1'b0;
            r_flagwrite_e <= '0;
            r_aluctl_e    <= '0;
            r_cond_e      <= '0;
        end else if (MemReady) begin
            if (FlushE) begin
                r_valid_e     <= 1'b0;
                r_pcsrc_e     <= 1'b0;
                r_regwrite_e  <= 1'b0;
                r_memtoreg_e  <= 1'b0;
                r_memwrite_e  <= 1'b0;
                r_branch_e    <= 1'b0;
                r_alusrc_e    <= 1'b0;
                r_nowrite_e   <= 1'b0;
                r_flagwrite_e <= '0;
                r_aluctl_e    <= '0;
                r_cond_e      <= '0;
            end else begin
                r_valid_e     <= ValidD;
                r_pcsrc_e     <= PCSrcD;
                r_regwrite_e  <= RegWriteD;
                r_memtoreg_e  <= MemtoRegD;
                r_memwrite_e  <= MemWriteD;
                r_branch_e    <= BranchD;
                r_alusrc_e    <= ALUSrcD;
                r_nowrite_e   <= NoWriteD;
                r_flagwrite_e <= FlagWriteD;
                r_aluctl_e    <= ALUControlD;
                r_cond_e      <= CondD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (MemReady && CondExE) begin
            if (r_flagwrite_e[1]) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (r_flagwrite_e[0]) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_STAGES; i++) r_mem[i] <= '0;
            r_wb <= '0;
        end else if (MemReady) begin
            r_mem[0] <= w_stage_e;
            for (int i = 1; i < MEM_STAGES; i++) r_mem[i] <= r_mem[i-1];
            r_wb <= r_mem[MEM_STAGES-1];
        end
    end

    always_comb begin
        PCBusy = w_stage_e.pc_src | r_wb.pc_src;
        for (int i = 0; i < MEM_STAGES; i++) PCBusy = PCBusy | r_mem[i].pc_src;
    end

    assign ALUSrcE     = r_alusrc_e;
    assign ALUControlE = r_aluctl_e;
    assign MemtoRegE   = r_memtoreg_e;
    assign MemWriteM   = r_mem[0].mem_write;
    assign RegWriteM   = r_mem[MEM_STAGES-1].reg_write;
    assign PCSrcM      = r_mem[MEM_STAGES-1].pc_src;
    assign RegWriteW   = r_wb.reg_write;
    assign MemtoRegW   = r_wb.mem_to_reg;
    assign PCSrcW      = r_wb.pc_src;
    assign Flags       = r_flags;
    assign w_unused    = ^{r_wb.valid, r_wb.mem_write};

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] r_retired, r_squashed, r_stall;

    // All three counters saturate rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired  <= '0;
            r_squashed <= '0;
            r_stall    <= '0;
        end else begin
            if (MemReady && r_wb.valid && (r_retired != '1))
                r_retired <= r_retired + PERF_W'(1);
            if (MemReady && r_valid_e && !w_pass && (r_squashed != '1))
                r_squashed <= r_squashed + PERF_W'(1);
            if (!MemReady && (r_stall != '1))
                r_stall <= r_stall + PERF_W'(1);
        end
    end

    assign PerfRetired  = r_retired;
    assign PerfSquashed = r_squashed;
    assign PerfStall    = r_stall;
`else
    assign PerfRetired  = '0;
    assign PerfSquashed = '0;
    assign PerfStall    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_pipe: directed self-checking bench for ctrl_pipe, MEM_STAGES=2.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD;
    logic        BranchD, ALUSrcD, NoWriteD;
    logic [1:0]  FlagWriteD;
    logic [2:0]  ALUControlD;
    logic [3:0]  CondD, ALUFlags;
    logic        FlushE, MemReady;
    logic        ALUSrcE, MemtoRegE, CondExE, BranchTakenE;
    logic [2:0]  ALUControlE;
    logic        MemWriteM, RegWriteM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW;
    logic        PCBusy;
    logic [3:0]  Flags;
    logic [31:0] PerfRetired, PerfSquashed, PerfStall;

    int n_cmp = 0;
    int n_err = 0;

    ctrl_pipe #(.ALUCTL_W(3), .MEM_STAGES(2), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .PCSrcD(PCSrcD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .NoWriteD(NoWriteD),
        .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD), .CondD(CondD),
        .ALUFlags(ALUFlags), .FlushE(FlushE), .MemReady(MemReady),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemtoRegE(MemtoRegE),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .PCSrcM(PCSrcM), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .PCBusy(PCBusy), .Flags(Flags),
        .PerfRetired(PerfRetired), .PerfSquashed(PerfSquashed), .PerfStall(PerfStall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_d();
        ValidD = 0; PCSrcD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
        BranchD = 0; ALUSrcD = 0; NoWriteD = 0; FlagWriteD = 0;
        ALUControlD = 0; CondD = 4'hE;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conds(input logic [15:0] exp, input string tag);
        for (int i = 0; i < 16; i++) begin
            clear_d();
            ValidD = 1; CondD = 4'(i);
            step();
            chk($sformatf("%s_c%0d", tag, i), {31'b0, CondExE}, {31'b0, exp[i]});
        end
        clear_d();
    endtask

    logic [31:0] exp_sq, exp_st;

    initial begin
        clear_d();
        ALUFlags = 0; FlushE = 0; MemReady = 1; reset = 0;
        #3;
        chk("rst_regwritew", {31'b0, RegWriteW}, 0);
        chk("rst_flags", {28'b0, Flags}, 0);
        chk("rst_pcbusy", {31'b0, PCBusy}, 0);
        chk("rst_condex", {31'b0, CondExE}, 0);
        #9 reset = 1;

        // Single AL register write reaches Writeback four edges later.
        ValidD = 1; RegWriteD = 1; CondD = 4'hE;
        step(); clear_d();
        chk("lat_condex", {31'b0, CondExE}, 1);
        chk("lat_w1", {31'b0, RegWriteW}, 0);
        step(); chk("lat_w2", {31'b0, RegWriteW}, 0);
        step(); chk("lat_m", {31'b0, RegWriteM}, 1);
        chk("lat_w3", {31'b0, RegWriteW}, 0);
        step(); chk("lat_w4", {31'b0, RegWriteW}, 1);
        chk("lat_flags", {28'b0, Flags}, 0);

        // CMP sets Z, then BEQ taken, then BNE squashed.
        ValidD = 1; FlagWriteD = 2'b11; CondD = 4'hE;
        step(); clear_d();
        ALUFlags = 4'b0100;
        chk("cmp_flags_before", {28'b0, Flags}, 0);
        ValidD = 1; BranchD = 1; CondD = 4'h0;
        step(); clear_d();
        ALUFlags = 4'b0000;
        chk("cmp_flags_after", {28'b0, Flags}, 32'h4);
        chk("beq_taken", {31'b0, BranchTakenE}, 1);
        ValidD = 1; BranchD = 1; CondD = 4'h1;
        step(); clear_d();
        chk("bne_taken", {31'b0, BranchTakenE}, 0);
        chk("bne_condex", {31'b0, CondExE}, 0);
        step();
`ifdef CTRL_PERF_EN
        exp_sq = 1;
`else
        exp_sq = 0;
`endif
        chk("bne_squashed", PerfSquashed, exp_sq);

        // Freeze: store in M1, reg-write in E, FlushE asserted but ignored.
        ValidD = 1; MemWriteD = 1; CondD = 4'hE;
        step(); clear_d();
        ValidD = 1; RegWriteD = 1; CondD = 4'hE;
        step(); clear_d();
        chk("frz_m1", {31'b0, MemWriteM}, 1);
        MemReady = 0; FlushE = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz_memw%0d", i), {31'b0, MemWriteM}, 1);
            chk($sformatf("frz_condex%0d", i), {31'b0, CondExE}, 1);
        end
`ifdef CTRL_PERF_EN
        exp_st = 3;
`else
        exp_st = 0;
`endif
        chk("frz_stall", PerfStall, exp_st);
        chk("frz_flags", {28'b0, Flags}, 32'h4);
        MemReady = 1; FlushE = 0;
        step();
        chk("frz_rel_memw", {31'b0, MemWriteM}, 0);
        chk("frz_rel_regm", {31'b0, RegWriteM}, 0);
        step();
        chk("frz_rel_regm2", {31'b0, RegWriteM}, 1);

        // Flush with a valid Decode instruction yields a bubble.
        ValidD = 1; RegWriteD = 1; PCSrcD = 1; ALUSrcD = 1; MemtoRegD = 1;
        ALUControlD = 3'b101; CondD = 4'hE; FlushE = 1;
        step(); clear_d(); FlushE = 0;
        chk("fl_condex", {31'b0, CondExE}, 0);
        chk("fl_alusrc", {31'b0, ALUSrcE}, 0);
        chk("fl_aluctl", {29'b0, ALUControlE}, 0);
        chk("fl_memtoreg", {31'b0, MemtoRegE}, 0);
        chk("fl_pcbusy", {31'b0, PCBusy}, 0);
        step(); step(); step();
        chk("fl_regw", {31'b0, RegWriteW}, 0);
        chk("fl_pcw", {31'b0, PCSrcW}, 0);

        // PC write keeps PCBusy up for MEM_STAGES+2 cycles.
        ValidD = 1; PCSrcD = 1; RegWriteD = 1; CondD = 4'hE;
        step(); clear_d();
        chk("pc_e", {31'b0, PCBusy}, 1);
        step(); chk("pc_m1", {31'b0, PCBusy}, 1);
        step(); chk("pc_m2", {31'b0, PCBusy}, 1);
        chk("pc_srcm", {31'b0, PCSrcM}, 1);
        step(); chk("pc_w", {31'b0, PCBusy}, 1);
        chk("pc_srcw", {31'b0, PCSrcW}, 1);
        step(); chk("pc_done", {31'b0, PCBusy}, 0);
        ValidD = 1; PCSrcD = 1; CondD = 4'hF;
        step(); clear_d();
        chk("pc_nv_e", {31'b0, PCBusy}, 0);
        step(); chk("pc_nv_m1", {31'b0, PCBusy}, 0);

        // Condition table with Z=1, then with N=1,C=1.
        run_conds(16'h66A9, "zset");
        ValidD = 1; FlagWriteD = 2'b11; CondD = 4'hE;
        step(); clear_d();
        ALUFlags = 4'b1010;
        step();
        ALUFlags = 4'b0000;
        chk("flags_nc", {28'b0, Flags}, 32'hA);
        run_conds(16'h6996, "ncset");

        // Asynchronous reset with three instructions in flight.
        for (int i = 0; i < 3; i++) begin
            clear_d();
            ValidD = 1; RegWriteD = 1; CondD = 4'hE;
            step();
        end
        clear_d();
        #2 reset = 0;
        #1;
        chk("ar_condex", {31'b0, CondExE}, 0);
        chk("ar_regm", {31'b0, RegWriteM}, 0);
        chk("ar_regw", {31'b0, RegWriteW}, 0);
        chk("ar_flags", {28'b0, Flags}, 0);
        #3 reset = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ar_post%0d", i), {31'b0, RegWriteW}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
